// File: rtl/gray_sweep_ctrl_if.sv
// Stream and control bundle between gray_sweep_ctrl and its surrounding logic.
// master = sequencer side, slave = requester/consumer side.
interface gray_sweep_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] first_code;
    logic [WIDTH-1:0] last_code;
    logic             loop;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             busy;
    logic             done;
    logic             chk_err;

    modport master (
        input  start, first_code, last_code, loop, abort, out_ready,
        output out_valid, bin_out, gray_out, busy, done, chk_err
    );

    modport slave (
        output start, first_code, last_code, loop, abort, out_ready,
        input  out_valid, bin_out, gray_out, busy, done, chk_err
    );
endinterface

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a binary range (with wrap/loop) and streams registered binary/Gray pairs.
// Optional consistency checker on chk_err is built when GRAY_SWEEP_CHECK_EN is defined.
module gray_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    gray_sweep_ctrl_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] first_q, first_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             loop_q, loop_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             xfer;

    assign xfer = (state_q == S_RUN) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            first_q <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            bin_q   <= '0;
            gray_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        loop_d  = loop_q;
        bin_d   = bin_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    first_d = bus.first_code;
                    last_d  = bus.last_code;
                    loop_d  = bus.loop;
                    bin_d   = bus.first_code;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // abort wins over a simultaneous transfer
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    if (bin_q == last_q) begin
                        if (loop_q) begin
                            bin_d = first_q;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        bin_d = bin_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Gray is derived from the next binary value so both registers update together.
    assign gray_d = bin_d ^ (bin_d >> 1);

    assign bus.out_valid = (state_q == S_RUN);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.bin_out   = bin_q;
    assign bus.gray_out  = gray_q;

`ifdef GRAY_SWEEP_CHECK_EN
    logic             prev_vld_q, prev_vld_d;
    logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vld_q  <= 1'b0;
            prev_gray_q <= '0;
            err_q       <= 1'b0;
        end else begin
            prev_vld_q  <= prev_vld_d;
            prev_gray_q <= prev_gray_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        prev_vld_d  = prev_vld_q;
        prev_gray_d = prev_gray_q;
        err_d       = err_q;
        if ((state_q == S_IDLE) && bus.start) begin
            prev_vld_d = 1'b0;
        end
        if (xfer) begin
            if (gray_q != (bin_q ^ (bin_q >> 1))) begin
                err_d = 1'b1;
            end
            if (prev_vld_q && ($countones(gray_q ^ prev_gray_q) != 1)) begin
                err_d = 1'b1;
            end
            prev_gray_d = gray_q;
            // a loop reload starts a new pass with no predecessor
            prev_vld_d  = !((bin_q == last_q) && loop_q);
        end
    end

    assign bus.chk_err = err_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_sweep_ctrl.sv
module tb_gray_sweep_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gray_sweep_ctrl_if #(.WIDTH(W)) bus ();
    gray_sweep_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
    } pair_t;

    typedef struct {
        logic [3:0] first;
        logic [3:0] last;
        int         len;
        logic [3:0] last_gray;
    } vec_t;

    pair_t      sbq[$];
    int         tests = 0;
    int         fails = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         last_xfer_cyc = 0;
    logic [3:0] last_gray = '0;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        logic [3:0] g;
        g[3] = b[3];
        for (int i = 0; i < 3; i++) g[i] = b[i] ^ b[i+1];
        return g;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [3:0] f, input int n);
        logic [3:0] b;
        for (int i = 0; i < n; i++) begin
            b = f + 4'(i);
            sbq.push_back('{bin: b, gray: to_gray(b)});
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: every accepted pair must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.out_valid && bus.out_ready) begin
                pair_t e;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_underflow: got bin %0d, expected no transfer", bus.bin_out);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_bin", int'(bus.bin_out), int'(e.bin));
                    chk("sb_gray", int'(bus.gray_out), int'(e.gray));
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
                last_gray = bus.gray_out;
            end
            if (bus.done) done_cnt++;
        end
    end

    task automatic run_sweep(input vec_t v);
        int x0;
        bit seen;
        x0 = xfer_cnt;
        seen = 1'b0;
        push_range(v.first, v.len);
        bus.first_code = v.first;
        bus.last_code  = v.last;
        bus.loop       = 1'b0;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                chk("done_valid_low", int'(bus.out_valid), 0);
                chk("done_busy", int'(bus.busy), 1);
                chk("done_latency", cyc - last_xfer_cyc, 1);
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done in 64 cycles, expected done");
        end
        chk("xfers", xfer_cnt - x0, v.len);
        chk("sb_drained", sbq.size(), 0);
        chk("last_gray", int'(last_gray), int'(v.last_gray));
        @(negedge clk);
        chk("busy_fall", int'(bus.busy), 0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[5];

    initial begin
        int x0;
        int d0;
        vecs[0] = '{first: 4'd0,  last: 4'd15, len: 16, last_gray: 4'b1000};
        vecs[1] = '{first: 4'd14, last: 4'd1,  len: 4,  last_gray: 4'b0001};
        vecs[2] = '{first: 4'd9,  last: 4'd9,  len: 1,  last_gray: 4'b1101};
        vecs[3] = '{first: 4'd5,  last: 4'd4,  len: 16, last_gray: 4'b0110};
        vecs[4] = '{first: 4'd3,  last: 4'd5,  len: 3,  last_gray: 4'b0111};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.first_code = '0;
        bus.last_code  = '0;
        bus.loop       = 1'b0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_bin", int'(bus.bin_out), 0);
        chk("rst_gray", int'(bus.gray_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_chk_err", int'(bus.chk_err), 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_sweep(vecs[i]);

        // Backpressure: ready 1,0,0,1,1 over a 3..5 sweep
        x0 = xfer_cnt;
        push_range(4'd3, 3);
        bus.first_code = 4'd3;
        bus.last_code  = 4'd5;
        bus.loop       = 1'b0;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall1_bin", int'(bus.bin_out), 4);
        chk("stall1_gray", int'(bus.gray_out), 4'b0110);
        tick();
        @(negedge clk);
        chk("stall2_bin", int'(bus.bin_out), 4);
        chk("stall2_gray", int'(bus.gray_out), 4'b0110);
        chk("stall2_valid", int'(bus.out_valid), 1);
        tick();
        bus.out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("bp_done", int'(bus.done), 1);
        chk("bp_xfers", xfer_cnt - x0, 3);
        tick();
        tick();

        // Loop 6..7 with an ignored start mid-run, then abort alongside a transfer
        x0 = xfer_cnt;
        d0 = done_cnt;
        push_range(4'd6, 2);
        push_range(4'd6, 2);
        push_range(4'd6, 1);
        bus.first_code = 4'd6;
        bus.last_code  = 4'd7;
        bus.loop       = 1'b1;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start      = 1'b1;
        bus.first_code = 4'd0;
        bus.last_code  = 4'd15;
        bus.loop       = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("loop_bin_before_abort", int'(bus.bin_out), 6);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", int'(bus.out_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("loop_xfers", xfer_cnt - x0, 5);
        chk("loop_sb_drained", sbq.size(), 0);
        tick();
        tick();
        chk("loop_no_done", done_cnt - d0, 0);

        // Reset in the middle of a sweep
        push_range(4'd0, 3);
        bus.first_code = 4'd0;
        bus.last_code  = 4'd15;
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_bin", int'(bus.bin_out), 0);
        chk("midrst_gray", int'(bus.gray_out), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_sb", sbq.size(), 0);
        tick();
        run_sweep(vecs[2]);

        chk("done_total", done_cnt, 7);
        chk("chk_err_final", int'(bus.chk_err), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
